// File: rtl/bus_fabric_pkg.sv
// Shared types for the bus fabric: FSM states, operation codes and a small
// helper that turns the master strobes into an operation code.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A write strobe selects OP_WR; anything else is treated as a read.
  function automatic op_t op_from_strobes(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Bus bundle between the master, the fabric and the slave instances.
// The "slave" modport is the fabric's view: it answers the master and
// drives the slave-side strobes. The "master" modport is the environment's
// view: the upstream master plus the slave devices that answer the fabric.
interface bus_fabric_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int NO_OF_SLAVES = 3
);
  localparam int SEL_W = $clog2(NO_OF_SLAVES);
  localparam int OFS_W = ADDR_WIDTH - SEL_W;

  logic [ADDR_WIDTH-1:0]              m_addr;
  logic [DATA_WIDTH-1:0]              m_wdata;
  logic                               m_rd;
  logic                               m_wr;
  logic [DATA_WIDTH-1:0]              m_rdata;
  logic                               m_ready;
  logic                               m_err;
  logic [NO_OF_SLAVES-1:0]            s_en;
  logic [OFS_W-1:0]                   s_addr;
  logic [DATA_WIDTH-1:0]              s_wdata;
  logic                               s_rd;
  logic                               s_wr;
  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] s_rdata;
  logic [NO_OF_SLAVES-1:0]            s_ready;

  modport master (
    output m_addr, m_wdata, m_rd, m_wr, s_rdata, s_ready,
    input  m_rdata, m_ready, m_err, s_en, s_addr, s_wdata, s_rd, s_wr
  );

  modport slave (
    input  m_addr, m_wdata, m_rd, m_wr, s_rdata, s_ready,
    output m_rdata, m_ready, m_err, s_en, s_addr, s_wdata, s_rd, s_wr
  );

endinterface

// File: rtl/bus_fabric_decoder.sv
// Combinational address decoder: splits the master address into a slave
// index and a slave-local offset, and flags indices with no slave behind them.
module bus_fabric_decoder #(
  parameter int ADDR_WIDTH   = 6,
  parameter int NO_OF_SLAVES = 3,
  localparam int SEL_W = $clog2(NO_OF_SLAVES),
  localparam int OFS_W = ADDR_WIDTH - SEL_W
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic [SEL_W-1:0]        sel,
  output logic [NO_OF_SLAVES-1:0] onehot,
  output logic                    hit,
  output logic [OFS_W-1:0]        ofs
);

  assign sel = addr[ADDR_WIDTH-1 -: SEL_W];
  assign ofs = addr[OFS_W-1:0];
  // Index values past the last slave are a decode miss.
  assign hit = (int'(sel) < NO_OF_SLAVES);

  for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_onehot
    assign onehot[gi] = hit && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric for NO_OF_SLAVES slaves.
// IDLE samples a request, ACCESS holds the selected slave's strobes until it
// reports ready, RESP returns a one-cycle m_ready with data and error flag.
// Illegal requests (read and write together) and decode misses skip ACCESS.
// Optional feature macro: BUS_FABRIC_TIMEOUT_EN adds an access timeout that
// ends ACCESS with an error after TIMEOUT_CYCLES cycles without s_ready.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 6,
  parameter int NO_OF_SLAVES   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  bus_fabric_if.slave bus
);

  localparam int SEL_W = $clog2(NO_OF_SLAVES);
  localparam int OFS_W = ADDR_WIDTH - SEL_W;

  if (NO_OF_SLAVES < 2) begin : g_bad_slaves
    $error("bus_fabric needs at least two slaves");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_fabric TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  state_reg, state_next;
  op_t                     op_reg;
  logic [OFS_W-1:0]        ofs_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [SEL_W-1:0]        sel_reg;
  logic [NO_OF_SLAVES-1:0] en_reg;
  logic                    err_reg;

  logic [SEL_W-1:0]        dec_sel;
  logic [NO_OF_SLAVES-1:0] dec_onehot;
  logic                    dec_hit;
  logic [OFS_W-1:0]        dec_ofs;

  logic                    req;
  logic                    reject;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_ready;
  logic                    timeout_hit;

  bus_fabric_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NO_OF_SLAVES (NO_OF_SLAVES)
  ) u_decoder (
    .addr   (bus.m_addr),
    .sel    (dec_sel),
    .onehot (dec_onehot),
    .hit    (dec_hit),
    .ofs    (dec_ofs)
  );

  assign req    = bus.m_rd | bus.m_wr;
  // Both strobes at once, or an address with no slave, is answered directly with an error.
  assign reject = (bus.m_rd & bus.m_wr) | ~dec_hit;

  // Pick read data and ready of the registered slave; other slaves' ready is ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (sel_reg == SEL_W'(i)) begin
        sel_rdata = bus.s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = bus.s_ready[i];
      end
    end
  end

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;

  // Count ACCESS cycles; zero on entry to ACCESS because it is held at zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == ACCESS) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else begin
      cnt_reg <= '0;
    end
  end

  // Fires on the ACCESS cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state_reg == ACCESS) &&
                       ((cnt_reg + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a ready slave takes priority over a timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = reject ? RESP : ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture in IDLE and response capture at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= OP_RD;
      ofs_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      sel_reg   <= '0;
      en_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            op_reg    <= op_from_strobes(bus.m_wr);
            ofs_reg   <= dec_ofs;
            wdata_reg <= bus.m_wdata;
            rdata_reg <= '0;
            sel_reg   <= dec_sel;
            en_reg    <= reject ? '0 : dec_onehot;
            err_reg   <= reject;
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            if (op_reg == OP_RD) rdata_reg <= sel_rdata;
            err_reg <= 1'b0;
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: slave strobes only in ACCESS, master response only in RESP.
  always_comb begin
    bus.s_en    = '0;
    bus.s_rd    = 1'b0;
    bus.s_wr    = 1'b0;
    bus.s_addr  = ofs_reg;
    bus.s_wdata = wdata_reg;
    bus.m_ready = 1'b0;
    bus.m_err   = 1'b0;
    bus.m_rdata = '0;
    if (state_reg == ACCESS) begin
      bus.s_en = en_reg;
      bus.s_rd = (op_reg == OP_RD);
      bus.s_wr = (op_reg == OP_WR);
    end
    if (state_reg == RESP) begin
      bus.m_ready = 1'b1;
      bus.m_err   = err_reg;
      bus.m_rdata = rdata_reg;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric with the default 8/6/3 geometry.
// Build with BUS_FABRIC_TIMEOUT_EN defined to exercise the timeout variant.
module tb_bus_fabric;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bus_fabric_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NO_OF_SLAVES(3)) bus ();

  bus_fabric #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (6),
    .NO_OF_SLAVES   (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_m_ready"}, 32'(bus.m_ready), 32'h0);
    check_value({tag, "_m_err"},   32'(bus.m_err),   32'h0);
    check_value({tag, "_m_rdata"}, 32'(bus.m_rdata), 32'h0);
    check_value({tag, "_s_en"},    32'(bus.s_en),    32'h0);
    check_value({tag, "_s_rd"},    32'(bus.s_rd),    32'h0);
    check_value({tag, "_s_wr"},    32'(bus.s_wr),    32'h0);
  endtask

  initial begin
    int n;
    int seen_ready;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_rd    = 1'b0;
    bus.m_wr    = 1'b0;
    bus.s_rdata = '0;
    bus.s_ready = '0;
    step();
    step();
    check_idle_outputs("reset");
    check_value("reset_s_addr",  32'(bus.s_addr),  32'h0);
    check_value("reset_s_wdata", 32'(bus.s_wdata), 32'h0);
    rst = 1'b0;

    // 1: zero-wait read from slave 0
    bus.s_rdata = {8'h11, 8'h22, 8'hA5};
    bus.s_ready = 3'b001;
    bus.m_addr  = 6'h05;
    bus.m_rd    = 1'b1;
    check_value("rd0_t0_m_ready", 32'(bus.m_ready), 32'h0);
    step();
    check_value("rd0_t1_s_en",    32'(bus.s_en),    32'h1);
    check_value("rd0_t1_s_addr",  32'(bus.s_addr),  32'h5);
    check_value("rd0_t1_s_rd",    32'(bus.s_rd),    32'h1);
    check_value("rd0_t1_m_ready", 32'(bus.m_ready), 32'h0);
    step();
    check_value("rd0_t2_m_ready", 32'(bus.m_ready), 32'h1);
    check_value("rd0_t2_m_rdata", 32'(bus.m_rdata), 32'hA5);
    check_value("rd0_t2_m_err",   32'(bus.m_err),   32'h0);
    check_value("rd0_t2_s_en",    32'(bus.s_en),    32'h0);
    bus.m_rd = 1'b0;
    step();
    check_idle_outputs("rd0_t3");
    $display("txn read  addr=0x05 done");

    // 2: write to slave 1 with three wait states; slaves 0 and 2 report ready meanwhile
    bus.s_ready = 3'b101;
    bus.m_addr  = 6'h12;
    bus.m_wdata = 8'h3C;
    bus.m_wr    = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_value($sformatf("wr1_acc%0d_s_en", k),    32'(bus.s_en),    32'h2);
      check_value($sformatf("wr1_acc%0d_s_wr", k),    32'(bus.s_wr),    32'h1);
      check_value($sformatf("wr1_acc%0d_s_wdata", k), 32'(bus.s_wdata), 32'h3C);
      check_value($sformatf("wr1_acc%0d_s_addr", k),  32'(bus.s_addr),  32'h2);
      check_value($sformatf("wr1_acc%0d_m_ready", k), 32'(bus.m_ready), 32'h0);
      if (k == 4) bus.s_ready = 3'b010;
    end
    step();
    check_value("wr1_t5_m_ready", 32'(bus.m_ready), 32'h1);
    check_value("wr1_t5_m_err",   32'(bus.m_err),   32'h0);
    check_value("wr1_t5_m_rdata", 32'(bus.m_rdata), 32'h0);
    bus.m_wr    = 1'b0;
    bus.s_ready = 3'b000;
    step();
    check_idle_outputs("wr1_t6");
    $display("txn write addr=0x12 data=0x3C done");

    // 3: decode miss
    bus.s_ready = 3'b111;
    bus.m_addr  = 6'h30;
    bus.m_rd    = 1'b1;
    step();
    check_value("miss_t1_m_ready", 32'(bus.m_ready), 32'h1);
    check_value("miss_t1_m_err",   32'(bus.m_err),   32'h1);
    check_value("miss_t1_m_rdata", 32'(bus.m_rdata), 32'h0);
    check_value("miss_t1_s_en",    32'(bus.s_en),    32'h0);
    bus.m_rd = 1'b0;
    step();
    check_idle_outputs("miss_t2");
    $display("txn read  addr=0x30 (miss) done");

    // 4: read and write together
    bus.m_addr = 6'h05;
    bus.m_rd   = 1'b1;
    bus.m_wr   = 1'b1;
    step();
    check_value("both_t1_m_ready", 32'(bus.m_ready), 32'h1);
    check_value("both_t1_m_err",   32'(bus.m_err),   32'h1);
    check_value("both_t1_m_rdata", 32'(bus.m_rdata), 32'h0);
    check_value("both_t1_s_en",    32'(bus.s_en),    32'h0);
    bus.m_rd = 1'b0;
    bus.m_wr = 1'b0;
    step();
    check_idle_outputs("both_t2");
    $display("txn rd+wr addr=0x05 (illegal) done");

    // 5a: slave 2 ready on its 16th ACCESS cycle; ready beats any timeout
    bus.s_ready = 3'b000;
    bus.s_rdata = {8'hC7, 8'h22, 8'hA5};
    bus.m_addr  = 6'h21;
    bus.m_rd    = 1'b1;
    step();
    check_value("late_acc1_s_en", 32'(bus.s_en), 32'h4);
    for (int k = 2; k <= 16; k++) step();
    check_value("late_acc16_m_ready", 32'(bus.m_ready), 32'h0);
    bus.s_ready = 3'b100;
    step();
    check_value("late_m_ready", 32'(bus.m_ready), 32'h1);
    check_value("late_m_err",   32'(bus.m_err),   32'h0);
    check_value("late_m_rdata", 32'(bus.m_rdata), 32'hC7);
    bus.m_rd    = 1'b0;
    bus.s_ready = 3'b000;
    step();
    $display("txn read  addr=0x21 (ready on 16th cycle) done");

    // 5b: slave 2 never ready
    bus.m_addr = 6'h20;
    bus.m_rd   = 1'b1;
    seen_ready = 0;
`ifdef BUS_FABRIC_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bus.m_ready) begin
        n = k;
        break;
      end
    end
    check_value("to_latency", 32'(n),           32'd17);
    check_value("to_m_err",   32'(bus.m_err),   32'h1);
    check_value("to_m_rdata", 32'(bus.m_rdata), 32'h0);
    bus.m_rd = 1'b0;
    step();
    check_idle_outputs("to_after");
    $display("txn read  addr=0x20 (timeout) done");
    // 6 setup: a read to slave 0 that stalls in ACCESS
    bus.m_addr = 6'h05;
    bus.m_rd   = 1'b1;
    step();
    check_value("rst_pre_s_en", 32'(bus.s_en), 32'h1);
`else
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bus.m_ready) seen_ready++;
    end
    check_value("hang_no_ready", 32'(seen_ready), 32'h0);
    check_value("hang_s_rd",     32'(bus.s_rd),   32'h1);
    check_value("rst_pre_s_en",  32'(bus.s_en),   32'h4);
    $display("txn read  addr=0x20 (no timeout, still waiting) done");
`endif

    // 6: reset in the middle of ACCESS, then a fresh read
    rst      = 1'b1;
    bus.m_rd = 1'b0;
    step();
    check_idle_outputs("rst_mid");
    check_value("rst_mid_s_addr",  32'(bus.s_addr),  32'h0);
    check_value("rst_mid_s_wdata", 32'(bus.s_wdata), 32'h0);
    rst         = 1'b0;
    bus.s_rdata = {8'h11, 8'h22, 8'h5A};
    bus.s_ready = 3'b001;
    bus.m_addr  = 6'h07;
    bus.m_rd    = 1'b1;
    step();
    check_value("post_rst_t1_s_en",   32'(bus.s_en),   32'h1);
    check_value("post_rst_t1_s_addr", 32'(bus.s_addr), 32'h7);
    step();
    check_value("post_rst_t2_m_ready", 32'(bus.m_ready), 32'h1);
    check_value("post_rst_t2_m_rdata", 32'(bus.m_rdata), 32'h5A);
    check_value("post_rst_t2_m_err",   32'(bus.m_err),   32'h0);
    bus.m_rd = 1'b0;
    step();
    check_idle_outputs("post_rst_t3");
    $display("txn read  addr=0x07 after reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on run time in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
